// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchroniser, start-bit validation, mid-bit sampling driven by
// the OVERSAMPLE x baud tick, and registered data_valid / frame_err pulses.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic                   rx_meta, rx_s;
  logic [TW-1:0]          tcnt, tcnt_nxt;
  logic [BW-1:0]          bcnt, bcnt_nxt;
  logic [DATA_BITS-1:0]   shreg, shreg_nxt;
  logic                   busy_nxt;
  logic                   done_ok, done_ok_nxt;
  logic                   done_err, done_err_nxt;

  // Two-flop synchroniser for the asynchronous serial line, idles high.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame state, counters, shift register and busy flag.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      bcnt     <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      done_ok  <= 1'b0;
      done_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      tcnt     <= tcnt_nxt;
      bcnt     <= bcnt_nxt;
      shreg    <= shreg_nxt;
      busy     <= busy_nxt;
      done_ok  <= done_ok_nxt;
      done_err <= done_err_nxt;
    end
  end

  // Next-state logic; nothing moves except on a tick.
  always_comb begin
    state_nxt    = state;
    tcnt_nxt     = tcnt;
    bcnt_nxt     = bcnt;
    shreg_nxt    = shreg;
    busy_nxt     = busy;
    done_ok_nxt  = 1'b0;
    done_err_nxt = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_nxt = S_START;
            tcnt_nxt  = '0;
            busy_nxt  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_START: begin
          if (tcnt == T_MID) begin
            tcnt_nxt = '0;
            if (!rx_s) begin
              state_nxt = S_DATA;
              bcnt_nxt  = '0;
            end else begin
              state_nxt = S_IDLE;
              busy_nxt  = 1'b0;
            end
          end else begin
            tcnt_nxt = tcnt + TW'(1'b1);
          end
        end
        S_DATA: begin
          if (tcnt == T_END) begin
            // LSB arrives first, so each new bit enters at the top and walks down.
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            tcnt_nxt  = '0;
            bcnt_nxt  = bcnt + BW'(1'b1);
            if (bcnt == B_LAST) begin
              state_nxt = S_STOP;
            end else begin
              state_nxt = S_DATA;
            end
          end else begin
            tcnt_nxt = tcnt + TW'(1'b1);
          end
        end
        S_STOP: begin
          if (tcnt == T_END) begin
            tcnt_nxt = '0;
            if (rx_s) begin
              state_nxt   = S_IDLE;
              busy_nxt    = 1'b0;
              done_ok_nxt = 1'b1;
            end else begin
              state_nxt    = S_BREAK;
              done_err_nxt = 1'b1;
            end
          end else begin
            tcnt_nxt = tcnt + TW'(1'b1);
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = S_BREAK;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          tcnt_nxt  = '0;
          bcnt_nxt  = '0;
          busy_nxt  = 1'b0;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Registered result pulses, one clk after the stop-bit sample; data_out holds between frames.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= done_ok;
      frame_err  <= done_err;
      if (done_ok || done_err) begin
        data_out <= shreg;
      end else begin
        data_out <= data_out;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, directed corner cases and randomized frames
// scored against a per-tick line-scan model of the receiver.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;

  logic       clk;
  logic       rst_a;
  logic       tick;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_a(rst_a), .tick(tick), .rx(rx),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  typedef struct { bit err; logic [7:0] data; int tidx; } ev_t;
  typedef struct { bit err; logic [7:0] data; int ed;   } pulse_t;
  typedef struct { logic [7:0] data; bit stop; int div; bit exp_err; logic [7:0] exp_data; } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         tick_div = 4;
  int         tick_cnt = 0;
  int         edge_n = 0;
  int         viol = 0;
  bit         busy_seen = 1'b0;
  bit         prev_dv = 1'b0;
  bit         prev_fe = 1'b0;
  logic       h1 = 1'b1;
  logic       h2 = 1'b1;
  logic [7:0] last_data = 8'h00;
  bit         samp[$];
  int         tick_edge[$];
  pulse_t     got[$];
  ev_t        exp_q[$];
  vec_t       tbl[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick     = 1'b1;
      tick_cnt = 0;
    end else begin
      tick     = 1'b0;
      tick_cnt = tick_cnt + 1;
    end
  end

  // Record the line as the receiver sees it on each tick (2 clk late) and every output pulse.
  always @(posedge clk) begin
    #1;
    edge_n = edge_n + 1;
    if (rst_a) begin
      h1 = 1'b1;
      h2 = 1'b1;
    end else begin
      if (tick) begin
        samp.push_back(h2);
        tick_edge.push_back(edge_n);
      end
      h2 = h1;
      h1 = rx;
    end
    if (data_valid) got.push_back('{1'b0, data_out, edge_n});
    if (frame_err)  got.push_back('{1'b1, data_out, edge_n});
    if (data_valid && frame_err) viol = viol + 1;
    if (data_valid && prev_dv)   viol = viol + 1;
    if (frame_err && prev_fe)    viol = viol + 1;
    prev_dv = data_valid;
    prev_fe = frame_err;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k = k + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
    rx = stop_bit;
    wait_ticks(OS);
  endtask

  // Scan the per-tick line: start at first low, verify half a bit later, then sample every OS ticks.
  task automatic run_model();
    int t, n, mid, stp;
    logic [7:0] d;
    ev_t e;
    exp_q.delete();
    n = samp.size();
    t = 0;
    while (1) begin
      while (t < n && samp[t]) t++;
      if (t >= n) break;
      mid = t + OS / 2;
      if (mid >= n) break;
      if (samp[mid]) begin
        t = mid + 1;
        continue;
      end
      stp = mid + OS * (DB + 1);
      if (stp >= n) break;
      for (int k = 0; k < DB; k++) d[k] = samp[mid + OS * (k + 1)];
      e.err  = !samp[stp];
      e.data = d;
      e.tidx = stp;
      exp_q.push_back(e);
      t = stp + 1;
      if (e.err) begin
        while (t < n && !samp[t]) t++;
        if (t >= n) break;
        t = t + 1;
      end
    end
  endtask

  task automatic check_segment(input string nm);
    int m;
    run_model();
    chk({nm, "/count"}, got.size(), exp_q.size());
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk({nm, "/kind"}, got[i].err, exp_q[i].err);
      chk({nm, "/data"}, got[i].data, exp_q[i].data);
      chk({nm, "/time"}, got[i].ed, tick_edge[exp_q[i].tidx] + 1);
    end
    if (exp_q.size() > 0) last_data = exp_q[exp_q.size() - 1].data;
    chk({nm, "/data_out_hold"}, data_out, last_data);
    samp.delete();
    tick_edge.delete();
    got.delete();
  endtask

  function automatic int tidx_of(input int ed);
    for (int i = 0; i < tick_edge.size(); i++) begin
      if (tick_edge[i] == ed - 1) return i;
    end
    return -1;
  endfunction

  initial begin
    logic [7:0] d;
    int ta, tb, dix, gap;
    bit sb;

    tbl[0] = '{8'hA5, 1'b1, 4, 1'b0, 8'hA5};
    tbl[1] = '{8'h00, 1'b1, 4, 1'b0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 3, 1'b0, 8'hFF};
    tbl[3] = '{8'h3C, 1'b0, 4, 1'b1, 8'h3C};
    tbl[4] = '{8'hC3, 1'b1, 1, 1'b0, 8'hC3};
    tbl[5] = '{8'h81, 1'b1, 2, 1'b0, 8'h81};
    tbl[6] = '{8'h55, 1'b0, 1, 1'b1, 8'h55};

    rst_a = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset/data_out", data_out, 8'h00);
    chk("reset/data_valid", data_valid, 1'b0);
    chk("reset/frame_err", frame_err, 1'b0);
    chk("reset/busy", busy, 1'b0);
    rst_a = 1'b0;
    samp.delete();
    tick_edge.delete();
    got.delete();
    idle(10);

    for (int i = 0; i < 7; i++) begin
      tick_div = tbl[i].div;
      idle(4);
      send_frame(tbl[i].data, tbl[i].stop);
      idle(20);
      chk("vec/pulses", got.size(), 1);
      if (got.size() >= 1) begin
        chk("vec/kind", got[0].err, tbl[i].exp_err);
        chk("vec/data", got[0].data, tbl[i].exp_data);
      end
      chk("vec/busy_after", busy, 1'b0);
      check_segment("vec");
    end

    tick_div = 4;
    idle(5);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(10);
    chk("b2b/pulses", got.size(), 2);
    if (got.size() == 2) begin
      chk("b2b/first", got[0].data, 8'h00);
      chk("b2b/second", got[1].data, 8'hFF);
      ta = tidx_of(got[0].ed);
      tb = tidx_of(got[1].ed);
      chk("b2b/tick_gap", tb - ta, 160);
    end
    check_segment("b2b");

    busy_seen = 1'b0;
    rx = 1'b0;
    wait_ticks(5);
    idle(20);
    chk("glitch/busy_seen", busy_seen, 1'b1);
    chk("glitch/busy_after", busy, 1'b0);
    chk("glitch/pulses", got.size(), 0);
    check_segment("glitch");

    send_frame(8'h3C, 1'b0);
    wait_ticks(40);
    chk("break/busy_held", busy, 1'b1);
    chk("break/pulses", got.size(), 1);
    if (got.size() >= 1) begin
      chk("break/kind", got[0].err, 1'b1);
      chk("break/data", got[0].data, 8'h3C);
    end
    rx = 1'b1;
    wait_ticks(1);
    chk("break/busy_release", busy, 1'b0);
    idle(20);
    check_segment("break");

    d = 8'h5A;
    idle(5);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
    rx = d[4];
    wait_ticks(OS / 2);
    check_segment("partial");
    rst_a = 1'b1;
    #1;
    chk("midreset/data_out", data_out, 8'h00);
    chk("midreset/data_valid", data_valid, 1'b0);
    chk("midreset/frame_err", frame_err, 1'b0);
    chk("midreset/busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rx = 1'b1;
    last_data = 8'h00;
    samp.delete();
    tick_edge.delete();
    idle(10);
    send_frame(8'h81, 1'b1);
    idle(10);
    chk("postreset/pulses", got.size(), 1);
    if (got.size() >= 1) chk("postreset/data", got[0].data, 8'h81);
    check_segment("postreset");

    tick_div = 1;
    idle(10);
    send_frame(8'hC3, 1'b1);
    idle(10);
    dix = 0;
    while (dix < samp.size() && samp[dix]) dix++;
    dix = dix + OS / 2 + OS * (DB + 1);
    chk("tickhigh/pulses", got.size(), 1);
    if (got.size() >= 1 && dix < tick_edge.size()) begin
      chk("tickhigh/data", got[0].data, 8'hC3);
      chk("tickhigh/latency", got[0].ed, tick_edge[dix] + 1);
    end
    check_segment("tickhigh");

    for (int s = 0; s < 4; s++) begin
      tick_div = $urandom_range(1, 3);
      idle(5);
      for (int f = 0; f < 6; f++) begin
        if ($urandom_range(0, 4) == 0) begin
          rx = 1'b0;
          wait_ticks($urandom_range(1, OS / 2 - 1));
          idle(OS);
        end
        d  = 8'($urandom);
        sb = ($urandom_range(0, 9) != 0);
        send_frame(d, sb);
        gap = sb ? $urandom_range(0, 6) : $urandom_range(2, 6);
        idle(gap);
      end
      idle(10);
      check_segment("random");
    end

    chk("pulse_rules", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
